// File: rtl/step_counter_register.sv
// step_counter_register
//   Load/count register with synchronous clear, up/down counting by a variable
//   step, and wrap modulo (LIMIT+1). Registered one-cycle CARRY/BORROW pulses
//   flag a wrap; ZERO/AT_LIMIT are decoded straight from the register value.
//
//   Optional feature macro: SATURATE_EN
//     defined   : overflow/underflow clamps to LIMIT/0 (CARRY/BORROW still pulse)
//     undefined : overflow/underflow wraps modulo (LIMIT+1)
//
// Ports
//   CLOCK      in   1          rising-edge clock
//   RESET_N    in   1          asynchronous active-low reset
//   CLEAR      in   1          synchronous clear to RESET_VALUE (highest priority)
//   LOAD       in   1          synchronous load of DATA (clamped to LIMIT)
//   INCREMENT  in   1          count up by step
//   DECREMENT  in   1          count down by step (both high -> hold)
//   STEP       in   STEP_BITS  step size, 0 means 1
//   DATA       in   BITS       load value
//   OUT        out  BITS       register value
//   ZERO       out  1          OUT == 0
//   AT_LIMIT   out  1          OUT == LIMIT
//   CARRY      out  1          pulse: last increment wrapped/clamped
//   BORROW     out  1          pulse: last decrement wrapped/clamped
module step_counter_register #(
  parameter int BITS        = 16,
  parameter int STEP_BITS   = 4,
  parameter int LIMIT       = 2**BITS - 1,
  parameter int RESET_VALUE = 0
) (
  input  logic                 CLOCK,
  input  logic                 RESET_N,
  input  logic                 CLEAR,
  input  logic                 LOAD,
  input  logic                 INCREMENT,
  input  logic                 DECREMENT,
  input  logic [STEP_BITS-1:0] STEP,
  input  logic [BITS-1:0]      DATA,
  output logic [BITS-1:0]      OUT,
  output logic                 ZERO,
  output logic                 AT_LIMIT,
  output logic                 CARRY,
  output logic                 BORROW
);

  // Parameter legality checks, evaluated at elaboration.
  localparam longint MAX_VAL  = (longint'(1) << BITS) - 1;
  localparam longint STEP_MAX = (longint'(1) << STEP_BITS) - 1;

  if (RESET_VALUE > LIMIT) begin : g_err_reset_value
    $error("step_counter_register: RESET_VALUE must not exceed LIMIT");
  end
  if (longint'(LIMIT) > MAX_VAL) begin : g_err_limit
    $error("step_counter_register: LIMIT does not fit in BITS");
  end
  if (STEP_MAX > longint'(LIMIT)) begin : g_err_step
    $error("step_counter_register: largest STEP must not exceed LIMIT");
  end

  // All count arithmetic is one bit wider than the register so that an
  // overflow past LIMIT is visible before any truncation.
  localparam logic [BITS:0]   LIM_W = (BITS+1)'(LIMIT);
  localparam logic [BITS-1:0] LIM_B = BITS'(LIMIT);
  localparam logic [BITS-1:0] RV_B  = BITS'(RESET_VALUE);
`ifndef SATURATE_EN
  localparam logic [BITS:0]   MOD_W = LIM_W + 1'b1;
`endif

  logic [BITS-1:0] out_q, out_d;
  logic            carry_q, carry_d;
  logic            borrow_q, borrow_d;
  logic [BITS:0]   step_w;
  logic [BITS:0]   cur_w;
  logic [BITS:0]   sum_w;

  always_comb begin
    out_d    = out_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    cur_w    = {1'b0, out_q};
    step_w   = (STEP == '0) ? (BITS+1)'(1) : (BITS+1)'(STEP);
    sum_w    = cur_w + step_w;

    if (CLEAR) begin
      out_d = RV_B;
    end else if (LOAD) begin
      out_d = ({1'b0, DATA} > LIM_W) ? LIM_B : DATA;
    end else if (INCREMENT && !DECREMENT) begin
      if (sum_w <= LIM_W) begin
        out_d = BITS'(sum_w);
      end else begin
        carry_d = 1'b1;
`ifdef SATURATE_EN
        out_d   = LIM_B;
`else
        out_d   = BITS'(sum_w - MOD_W);
`endif
      end
    end else if (DECREMENT && !INCREMENT) begin
      if (step_w <= cur_w) begin
        out_d = BITS'(cur_w - step_w);
      end else begin
        borrow_d = 1'b1;
`ifdef SATURATE_EN
        out_d    = '0;
`else
        // cur + (LIMIT+1) - step cannot exceed BITS+1 bits.
        out_d    = BITS'(cur_w + MOD_W - step_w);
`endif
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      out_q    <= RV_B;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign OUT      = out_q;
  assign CARRY    = carry_q;
  assign BORROW   = borrow_q;
  assign ZERO     = (out_q == '0);
  assign AT_LIMIT = (out_q == LIM_B);

endmodule

// File: tb/tb_step_counter_register.sv
module tb_step_counter_register;

  localparam int BITS        = 8;
  localparam int STEP_BITS   = 3;
  localparam int LIMIT       = 9;
  localparam int RESET_VALUE = 0;
`ifdef SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic                 CLOCK;
  logic                 RESET_N;
  logic                 CLEAR;
  logic                 LOAD;
  logic                 INCREMENT;
  logic                 DECREMENT;
  logic [STEP_BITS-1:0] STEP;
  logic [BITS-1:0]      DATA;
  logic [BITS-1:0]      OUT;
  logic                 ZERO;
  logic                 AT_LIMIT;
  logic                 CARRY;
  logic                 BORROW;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  step_counter_register #(
    .BITS(BITS), .STEP_BITS(STEP_BITS), .LIMIT(LIMIT), .RESET_VALUE(RESET_VALUE)
  ) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .CLEAR(CLEAR), .LOAD(LOAD),
    .INCREMENT(INCREMENT), .DECREMENT(DECREMENT), .STEP(STEP), .DATA(DATA),
    .OUT(OUT), .ZERO(ZERO), .AT_LIMIT(AT_LIMIT), .CARRY(CARRY), .BORROW(BORROW)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: value of the counter as an ordinary integer in 0..LIMIT.
  int m  = RESET_VALUE;
  bit mc = 1'b0;
  bit mb = 1'b0;

  always @(posedge CLOCK or negedge RESET_N) begin
    int s;
    int nv;
    bit nc;
    bit nb;
    if (!RESET_N) begin
      m  <= RESET_VALUE;
      mc <= 1'b0;
      mb <= 1'b0;
    end else begin
      s  = (STEP == 0) ? 1 : int'(STEP);
      nv = m;
      nc = 1'b0;
      nb = 1'b0;
      if (CLEAR) nv = RESET_VALUE;
      else if (LOAD) nv = (int'(DATA) > LIMIT) ? LIMIT : int'(DATA);
      else if (INCREMENT && !DECREMENT) begin
        if (m + s <= LIMIT) nv = m + s;
        else begin
          nc = 1'b1;
          nv = SAT ? LIMIT : (m + s) % (LIMIT + 1);
        end
      end else if (DECREMENT && !INCREMENT) begin
        if (s <= m) nv = m - s;
        else begin
          nb = 1'b1;
          nv = SAT ? 0 : (m - s + LIMIT + 1);
        end
      end
      m  <= nv;
      mc <= nc;
      mb <= nb;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge CLOCK) begin
    if (chk_en) begin
      check("out",      int'(OUT),      m);
      check("zero",     int'(ZERO),     int'(m == 0));
      check("at_limit", int'(AT_LIMIT), int'(m == LIMIT));
      check("carry",    int'(CARRY),    int'(mc));
      check("borrow",   int'(BORROW),   int'(mb));
    end
  end

  // Apply one command just after a rising edge; return 1 ns after the edge
  // that executes it, so OUT already reflects the command.
  task automatic cyc(input bit clr, input bit ld, input bit inc, input bit dec,
                     input int st, input int d);
    CLEAR     = clr;
    LOAD      = ld;
    INCREMENT = inc;
    DECREMENT = dec;
    STEP      = STEP_BITS'(st);
    DATA      = BITS'(d);
    @(posedge CLOCK);
    #1;
  endtask

  initial begin
    RESET_N = 1'b0; CLEAR = 0; LOAD = 0; INCREMENT = 0; DECREMENT = 0;
    STEP = '0; DATA = '0;
    repeat (2) @(posedge CLOCK);
    #1;
    check("reset_out",  int'(OUT), 0);
    check("reset_zero", int'(ZERO), 1);
    RESET_N = 1'b1;
    chk_en  = 1'b1;

    // Load then increment with STEP=0 (treated as 1).
    cyc(0, 1, 0, 0, 0, 7);
    check("load7", int'(OUT), 7);
    cyc(0, 0, 1, 0, 0, 0);
    check("inc_step0", int'(OUT), 8);
    check("inc_step0_carry", int'(CARRY), 0);

    // 8 + 3 overflows.
    cyc(0, 0, 1, 0, 3, 0);
    check("inc_wrap_out", int'(OUT), SAT ? 9 : 1);
    check("inc_wrap_carry", int'(CARRY), 1);
    check("inc_wrap_atlim", int'(AT_LIMIT), SAT ? 1 : 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("carry_pulse_end", int'(CARRY), 0);

    // 2 - 5 underflows.
    cyc(0, 1, 0, 0, 0, 2);
    cyc(0, 0, 0, 1, 5, 0);
    check("dec_wrap_out", int'(OUT), SAT ? 0 : 7);
    check("dec_wrap_borrow", int'(BORROW), 1);
    check("dec_wrap_zero", int'(ZERO), SAT ? 1 : 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("borrow_pulse_end", int'(BORROW), 0);

    // Priority.
    cyc(0, 1, 0, 0, 0, 6);
    cyc(1, 1, 1, 0, 1, 4);
    check("clear_wins", int'(OUT), 0);
    cyc(0, 1, 0, 0, 0, 6);
    cyc(0, 1, 1, 0, 1, 4);
    check("load_wins", int'(OUT), 4);
    cyc(0, 1, 0, 0, 0, 6);
    cyc(0, 0, 1, 1, 2, 0);
    check("inc_dec_hold", int'(OUT), 6);
    check("inc_dec_carry", int'(CARRY), 0);
    check("inc_dec_borrow", int'(BORROW), 0);

    // Load clamp, then ten single steps through the limit.
    cyc(0, 1, 0, 0, 0, 200);
    check("load_clamp", int'(OUT), 9);
    check("load_clamp_atlim", int'(AT_LIMIT), 1);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 1, 0, 1, 0);
      check("walk_out", int'(OUT), SAT ? 9 : i);
      check("walk_carry", int'(CARRY), (SAT || i == 0) ? 1 : 0);
    end

    // Asynchronous reset mid-cycle after a wrapping increment (8+7 -> 5).
    cyc(0, 1, 0, 0, 0, 8);
    cyc(0, 0, 1, 0, 7, 0);
    check("pre_reset_out", int'(OUT), SAT ? 9 : 5);
    check("pre_reset_carry", int'(CARRY), 1);
    CLEAR = 0; LOAD = 0; INCREMENT = 0; DECREMENT = 0;
    #2;
    RESET_N = 1'b0;
    #1;
    check("async_rst_out", int'(OUT), 0);
    check("async_rst_zero", int'(ZERO), 1);
    check("async_rst_carry", int'(CARRY), 0);
    check("async_rst_borrow", int'(BORROW), 0);
    @(posedge CLOCK);
    #1;
    check("rst_held", int'(OUT), 0);
    RESET_N = 1'b1;
    cyc(0, 0, 1, 0, 2, 0);
    check("first_edge_after_rst", int'(OUT), 2);

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
    end

    CLEAR = 0; LOAD = 0; INCREMENT = 0; DECREMENT = 0;
    @(negedge CLOCK);
    #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
